axi4_cmd_master: RTL
====================

// Module: axi4_cmd_master
// PURPOSE
//  Single-outstanding AXI4 (single-beat, 32-bit data) master that sits directly upstream of the
//  register/memory slave. It converts a simple valid/ready command stream into AW/W/B or AR/R
//  transactions and returns one response per command. It is the bus driver for the testbench
//  sequencer and for future CPU-side logic.
// PARAMETERS
//  ADDR_W   32   address width driven on awaddr/araddr (upper bits zero-filled to 32)
//  TIMEOUT  256  max cycles waiting for bvalid/rvalid before abandoning; must be >= 2
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       command accepted when cmd_valid && cmd_ready
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  byte address
//  cmd_wdata    in   32      write data (ignored for reads)
//  cmd_wstrb    in   4       write strobes (ignored for reads)
//  rsp_valid    out  1       response present; held until rsp_ready
//  rsp_ready    in   1       response consumer ready
//  rsp_rdata    out  32      read data (0 for writes and timeouts)
//  rsp_resp     out  2       bresp/rresp copied from the bus; 2'b10 on timeout
//  rsp_timeout  out  1       1 = transaction abandoned by the timeout counter
//  axi_if       axi4_if.master  drives aw*/w*/ar*/bready/rready; samples *ready/b*/r*
// BEHAVIOUR
//  Reset: all valids, bready, rready, rsp_valid and rsp_timeout are 0; addr/data/resp are 0;
//   state = IDLE; timeout counter = 0. Asserting reset mid-transaction aborts it immediately
//   and returns the block to IDLE. No response is produced for the aborted command.
//  FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
//  IDLE: cmd_ready = 1 (combinational on state). On accept, the command is registered.
//   write -> WR_REQ and read -> RD_REQ. In the next cycle, awvalid/wvalid or arvalid are 1.
//  WR_REQ: awvalid and wvalid rise in the same cycle. Each is dropped only after its own
//   handshake; aw_done/w_done flags track this. awaddr, wdata and wstrb are stable while valid.
//   When both handshakes are done, in the same or different cycles, the FSM goes to WR_RESP.
//  WR_RESP: bready = 1. On bvalid, capture bresp and go to RSP.
//  RD_REQ: arvalid = 1 until arready. Then go to RD_RESP.
//  RD_RESP: rready = 1. On rvalid, capture rdata/rresp and go to RSP.
//  Timeout: the counter clears on entry to WR_RESP/RD_RESP and increments each waiting cycle.
//   At TIMEOUT-1 with no bvalid/rvalid: drop bready/rready, set rsp_resp = 2'b10,
//   set rsp_timeout = 1, and go to RSP. A late bvalid/rvalid arriving in IDLE is ignored;
//   bready/rready stay 0 in that case.
//  Address/data phases never time out, because AXI forbids dropping valid before ready.
//  RSP: rsp_valid = 1, with outputs stable until rsp_ready. Then go to IDLE, so
//   cmd_ready = 1 the next cycle. Commands are never accepted while rsp_valid = 1.
//  Minimum latency against an always-ready slave: accept at T0, valids at T1, bvalid/rvalid
//   at T2, rsp_valid at T3.
//  Simultaneous events: awready and wready in the same cycle go straight to WR_RESP.
//   A bvalid arriving in the timeout cycle wins: it is captured as a normal response.
// TESTING
//  1. Reset, then write 0xDEADBEEF to 0x10, strb 0xF -> one AW+W beat, rsp_valid at T3,
//     rsp_resp 0, rsp_timeout 0.
//  2. Read 0x10 after test 1 -> rsp_rdata 0xDEADBEEF, rsp_resp 0.
//  3. Stub slave with awready at cycle 1 and wready at cycle 4 -> awvalid drops after
//     cycle 1, wvalid held until cycle 4, a single bresp.
//  4. Slave never asserts rvalid -> after TIMEOUT cycles rsp_timeout 1, rsp_resp 2'b10,
//     rsp_rdata 0.
//  5. rsp_ready held 0 for 10 cycles -> rsp_valid/data stable, cmd_ready 0 throughout.
//  6. Reset asserted while in WR_REQ -> all valids 0 asynchronously, IDLE, no rsp_valid.

Source files
------------

// File: rtl/axi4_if.sv
// AXI4 single-beat, 32-bit data bus bundle.
// Master drives requests; slave drives readies and responses.
interface axi4_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_cmd_master.sv
// Single-outstanding AXI4 master: one command in, one bus
// transaction out, one response back; waits bounded by TIMEOUT.
module axi4_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  axi4_if.master            axi_if
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              tout_q, tout_d;
  logic              aw_now, w_now;

  assign cmd_ready      = (state_q == IDLE);
  assign rsp_valid      = (state_q == RSP);
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign rsp_timeout    = tout_q;

  assign axi_if.awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign axi_if.wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign axi_if.arvalid = (state_q == RD_REQ);
  assign axi_if.bready  = (state_q == WR_RESP);
  assign axi_if.rready  = (state_q == RD_RESP);
  assign axi_if.awaddr  = 32'(addr_q);
  assign axi_if.araddr  = 32'(addr_q);
  assign axi_if.wdata   = wdata_q;
  assign axi_if.wstrb   = wstrb_q;

  // A channel counts as done once its valid has met ready.
  assign aw_now = aw_done_q | axi_if.awready;
  assign w_now  = w_done_q  | axi_if.wready;

  // State and captured command/response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      tout_q    <= tout_d;
    end
  end

  // Next-state: sequence the bus phases and the timeout.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tout_d    = tout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = '0;
          tout_d    = 1'b0;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) begin
          cnt_d   = '0;
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi_if.bvalid) begin
          resp_d  = axi_if.bresp;
          state_d = RSP;
        end else if (cnt_q == LAST) begin
          resp_d  = 2'b10;
          tout_d  = 1'b1;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_REQ: begin
        if (axi_if.arready) begin
          cnt_d   = '0;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (axi_if.rvalid) begin
          rdata_d = axi_if.rdata;
          resp_d  = axi_if.rresp;
          state_d = RSP;
        end else if (cnt_q == LAST) begin
          resp_d  = 2'b10;
          tout_d  = 1'b1;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
